// File: rtl/adder_multiword_sequencer.sv
// Multi-word adder/subtractor: one WORD_WIDTH-bit slice per beat, LS word first.
// Carry is chained across beats; signed/unsigned predicates are reported on the last word.
module adder_multiword_sequencer #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned WORD_COUNT = 2
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  sub_in,
    input  logic [WORD_WIDTH-1:0] A_in,
    input  logic [WORD_WIDTH-1:0] B_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] sum_out,
    output logic                  out_last,
    output logic                  carry_out,
    output logic                  overflow,
    output logic                  zero,
    output logic                  lt_signed,
    output logic                  lt_unsigned
);

    localparam int unsigned CntW = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WORD_COUNT - 1);
    localparam int unsigned Msb = WORD_WIDTH - 1;

    // Operation state
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            op_sub_q, op_sub_d;
    logic            zacc_q, zacc_d;

    // Output register
    logic                  out_valid_q, out_valid_d;
    logic [WORD_WIDTH-1:0] sum_q, sum_d;
    logic                  last_q, last_d;
    logic                  carry_out_q, carry_out_d;
    logic                  overflow_q, overflow_d;
    logic                  zero_q, zero_d;
    logic                  lt_signed_q, lt_signed_d;
    logic                  lt_unsigned_q, lt_unsigned_d;

    // Datapath intermediates
    logic                  accept;
    logic                  first;
    logic                  last;
    logic                  sub;
    logic [WORD_WIDTH-1:0] b_eff;
    logic                  cin;
    logic [WORD_WIDTH:0]   sum_ext;
    logic [WORD_WIDTH-1:0] s;
    logic                  cout;
    logic                  zacc_beat;
    logic                  msb_cin;
    logic                  ovf_beat;

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    // Per-beat word slice of the wide add; the first beat injects the two's-complement +1.
    always_comb begin
        first     = (cnt_q == '0);
        last      = (cnt_q == LastCnt);
        sub       = first ? sub_in : op_sub_q;
        b_eff     = sub ? ~B_in : B_in;
        cin       = first ? sub : carry_q;
        sum_ext   = {1'b0, A_in} + {1'b0, b_eff} + {{WORD_WIDTH{1'b0}}, cin};
        s         = sum_ext[WORD_WIDTH-1:0];
        cout      = sum_ext[WORD_WIDTH];
        zacc_beat = first ? (s == '0) : (zacc_q & (s == '0));
        // Carry into the MSB is recovered from the sum bit rather than a second adder.
        msb_cin   = A_in[Msb] ^ b_eff[Msb] ^ s[Msb];
        ovf_beat  = cout ^ msb_cin;
    end

    // Next-state for beat counter, carry chain, latched op and zero accumulator.
    always_comb begin
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        op_sub_d = op_sub_q;
        zacc_d   = zacc_q;
        if (accept) begin
            cnt_d    = last ? '0 : cnt_q + CntW'(1);
            carry_d  = cout;
            op_sub_d = sub;
            zacc_d   = zacc_beat;
        end
    end

    // Next-state for the output stage; flags only populated on the final word.
    always_comb begin
        out_valid_d   = out_valid_q;
        sum_d         = sum_q;
        last_d        = last_q;
        carry_out_d   = carry_out_q;
        overflow_d    = overflow_q;
        zero_d        = zero_q;
        lt_signed_d   = lt_signed_q;
        lt_unsigned_d = lt_unsigned_q;
        if (accept) begin
            out_valid_d   = 1'b1;
            sum_d         = s;
            last_d        = last;
            carry_out_d   = last & cout;
            overflow_d    = last & ovf_beat;
            zero_d        = last & zacc_beat;
            lt_signed_d   = last & sub & (s[Msb] ^ ovf_beat);
            lt_unsigned_d = last & sub & ~cout;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; clear wins over any handshake in the same cycle.
    always_ff @(posedge clock) begin
        if (clear) begin
            cnt_q         <= '0;
            carry_q       <= 1'b0;
            op_sub_q      <= 1'b0;
            zacc_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            sum_q         <= '0;
            last_q        <= 1'b0;
            carry_out_q   <= 1'b0;
            overflow_q    <= 1'b0;
            zero_q        <= 1'b0;
            lt_signed_q   <= 1'b0;
            lt_unsigned_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            carry_q       <= carry_d;
            op_sub_q      <= op_sub_d;
            zacc_q        <= zacc_d;
            out_valid_q   <= out_valid_d;
            sum_q         <= sum_d;
            last_q        <= last_d;
            carry_out_q   <= carry_out_d;
            overflow_q    <= overflow_d;
            zero_q        <= zero_d;
            lt_signed_q   <= lt_signed_d;
            lt_unsigned_q <= lt_unsigned_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign sum_out     = sum_q;
    assign out_last    = last_q;
    assign carry_out   = carry_out_q;
    assign overflow    = overflow_q;
    assign zero        = zero_q;
    assign lt_signed   = lt_signed_q;
    assign lt_unsigned = lt_unsigned_q;

endmodule

// File: tb/tb_adder_multiword_sequencer.sv
// Scoreboard bench for adder_multiword_sequencer with 8-bit words, 2 words per operation.
module tb_adder_multiword_sequencer;

    localparam int unsigned W = 8;
    localparam int unsigned N = 2;

    logic         clock;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic         sub_in;
    logic [W-1:0] A_in;
    logic [W-1:0] B_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum_out;
    logic         out_last;
    logic         carry_out;
    logic         overflow;
    logic         zero;
    logic         lt_signed;
    logic         lt_unsigned;

    adder_multiword_sequencer #(
        .WORD_WIDTH(W),
        .WORD_COUNT(N)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sub_in     (sub_in),
        .A_in       (A_in),
        .B_in       (B_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum_out    (sum_out),
        .out_last   (out_last),
        .carry_out  (carry_out),
        .overflow   (overflow),
        .zero       (zero),
        .lt_signed  (lt_signed),
        .lt_unsigned(lt_unsigned)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         last;
        logic         carry;
        logic         ovf;
        logic         zero;
        logic         lts;
        logic         ltu;
    } beat_t;

    beat_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: full 16-bit arithmetic, split into per-beat expectations.
    task automatic expect_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                             input int nbeats);
        logic [16:0] full;
        logic [15:0] r;
        logic        ovf;
        beat_t       e;
        full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + 17'(sub);
        r    = full[15:0];
        ovf  = sub ? ((a[15] != b[15]) && (r[15] != a[15]))
                   : ((a[15] == b[15]) && (r[15] != a[15]));
        e     = '0;
        e.sum = r[7:0];
        sb.push_back(e);
        if (nbeats > 1) begin
            e.sum   = r[15:8];
            e.last  = 1'b1;
            e.carry = full[16];
            e.ovf   = ovf;
            e.zero  = (r == 16'h0000);
            e.lts   = sub && ($signed(a) < $signed(b));
            e.ltu   = sub && (a < b);
            sb.push_back(e);
        end
    endtask

    // Offer one beat and hold it until the handshake completes.
    task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                              output int stalls);
        in_valid = 1'b1;
        A_in     = a;
        B_in     = b;
        sub_in   = s;
        stalls   = 0;
        while (1) begin
            @(negedge clock);
            if (in_ready) break;
            stalls++;
            if (stalls > 50) begin
                check("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Second beat deliberately offers the opposite sub_in: it must be ignored.
    task automatic send_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                           output int stalls);
        int st0;
        int st1;
        expect_op(a, b, s, 2);
        drive_beat(a[7:0], b[7:0], s, st0);
        drive_beat(a[15:8], b[15:8], ~s, st1);
        stalls = st0 + st1;
    endtask

    // Pop and compare every completed output handshake.
    always @(negedge clock) begin
        beat_t e;
        if (!clear && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sum_out", 32'(sum_out), 32'(e.sum));
                check("out_last", 32'(out_last), 32'(e.last));
                check("carry_out", 32'(carry_out), 32'(e.carry));
                check("overflow", 32'(overflow), 32'(e.ovf));
                check("zero", 32'(zero), 32'(e.zero));
                check("lt_signed", 32'(lt_signed), 32'(e.lts));
                check("lt_unsigned", 32'(lt_unsigned), 32'(e.ltu));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        clear     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sub_in    = 1'b0;
        A_in      = '0;
        B_in      = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum_out), 32'd0);
        check("rst_flags", {26'd0, out_last, carry_out, overflow, zero, lt_signed, lt_unsigned},
              32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        clear = 1'b0;

        // Directed operations
        send_op(16'h00FF, 16'h0001, 1'b0, st);
        send_op(16'h8000, 16'h0001, 1'b1, st);
        send_op(16'h1234, 16'h1234, 1'b1, st);
        repeat (3) @(posedge clock);
        #1;

        // Backpressure: first beat held in the output register for three cycles
        expect_op(16'h00FF, 16'h0001, 1'b0, 2);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        A_in      = 8'hFF;
        B_in      = 8'h01;
        sub_in    = 1'b0;
        @(posedge clock);
        #1;
        A_in   = 8'h00;
        B_in   = 8'h00;
        sub_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(sum_out), 32'h00);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_last", 32'(out_last), 32'd0);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Clear mid-operation: the pending borrow must not leak into the next op
        expect_op(16'h0000, 16'h0001, 1'b1, 1);
        drive_beat(8'h00, 8'h01, 1'b1, st);
        @(posedge clock);
        #1;
        clear = 1'b1;
        @(posedge clock);
        #1;
        check("clr_out_valid", 32'(out_valid), 32'd0);
        check("clr_sum", 32'(sum_out), 32'd0);
        check("clr_last", 32'(out_last), 32'd0);
        check("clr_in_ready", 32'(in_ready), 32'd1);
        clear = 1'b0;
        send_op(16'h0001, 16'h0001, 1'b0, st);

        // Back-to-back operations at full throughput
        send_op(16'h0000, 16'h0001, 1'b1, st);
        check("b2b_stalls_op1", 32'(st), 32'd0);
        send_op(16'h0001, 16'h0001, 1'b0, st);
        check("b2b_stalls_op2", 32'(st), 32'd0);

        // Random operations with random idle gaps
        for (int i = 0; i < 24; i++) begin
            send_op(16'($urandom), 16'($urandom), 1'($urandom), st);
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clock);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
